pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit: operand forwarding, stall/flush steering, memory-wait FSM.
// In: stage addresses/enables, memop/mem_ready, pcsrc_*, branch. Out: fwd_e, stall_*, flush_*, mem_wait/mem_err, counters.
module pipeline_hazard_ctrl #(
  parameter int NRP     = 2,
  parameter int AW      = 4,
  parameter int PC_REG  = 15,
  parameter int FWD_EN  = 1,
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRP*AW-1:0] ra_d,
  input  logic [NRP*AW-1:0] ra_e,
  input  logic [AW-1:0]     wa_e,
  input  logic [AW-1:0]     wa_m,
  input  logic [AW-1:0]     wa_w,
  input  logic              regwrite_e,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              memtoreg_e,
  input  logic              memop_m,
  input  logic              mem_ready,
  input  logic              pcsrc_d,
  input  logic              pcsrc_e,
  input  logic              pcsrc_m,
  input  logic              pcsrc_w,
  input  logic              branch_taken_e,
  output logic [2*NRP-1:0]  fwd_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              mem_wait,
  output logic              mem_err,
  output logic [CW-1:0]     stall_cnt,
  output logic [CW-1:0]     flush_cnt
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMAX = WW'(TIMEOUT);

  if (PC_REG < 0 || PC_REG >= (1 << AW)) begin : g_bad_pc
    $error("PC_REG outside the register address space");
  end

  typedef enum logic {S_RUN, S_WAIT} st_t;

  st_t           st;
  logic [WW-1:0] wcnt;

  logic [NRP-1:0] ld_hit;
  logic [NRP-1:0] raw_hit;
  logic           ldstall;
  logic           rawstall;
  logic           pcpend;
  logic           memstall;

  for (genvar i = 0; i < NRP; i++) begin : g_port
    logic [AW-1:0] rd;
    logic [AW-1:0] re;
    logic          m_hit;
    logic          w_hit;

    assign rd = ra_d[i*AW +: AW];
    assign re = ra_e[i*AW +: AW];

    assign ld_hit[i]  = (rd == wa_e);
    assign raw_hit[i] = (regwrite_e && rd == wa_e)
                     || (regwrite_m && rd == wa_m);

    assign m_hit = regwrite_m && (re == wa_m);
    assign w_hit = regwrite_w && (re == wa_w);

    // M wins over W: it holds the younger result
    assign fwd_e[2*i +: 2] =
      (FWD_EN == 0) ? 2'b00 :
      m_hit         ? 2'b10 :
      w_hit         ? 2'b01 :
                      2'b00;
  end

  assign ldstall  = memtoreg_e && (|ld_hit);
  assign rawstall = (FWD_EN == 0) ? (|raw_hit) : 1'b0;
  assign pcpend   = pcsrc_d | pcsrc_e | pcsrc_m;
  assign memstall = memop_m & ~mem_ready;

  assign stall_f = memstall | ldstall | rawstall | pcpend;
  assign stall_d = memstall | ldstall | rawstall;
  assign stall_e = memstall;
  assign stall_m = memstall;

  // A frozen pipe must not bubble anything it still holds
  assign flush_w = memstall;
  assign flush_e = ~memstall & (ldstall | rawstall | branch_taken_e);
  assign flush_d = ~memstall & (pcpend | pcsrc_w | branch_taken_e);

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= S_RUN;
      wcnt     <= '0;
      mem_wait <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      unique case (st)
        S_RUN: begin
          if (memstall) begin
            st       <= S_WAIT;
            mem_wait <= 1'b1;
            wcnt     <= '0;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            st       <= S_RUN;
            mem_wait <= 1'b0;
          end
          if (wcnt != TMAX)
            wcnt <= wcnt + WW'(1);
          if (wcnt == TMAX && !mem_ready)
            mem_err <= 1'b1;
        end
        default: begin
          st       <= S_RUN;
          mem_wait <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && stall_cnt != '1)
        stall_cnt <= stall_cnt + CW'(1);
      if (flush_d && flush_cnt != '1)
        flush_cnt <= flush_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Instance a: forwarding, TIMEOUT=4. Instance b: stall-only, CW=4.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ra_d, ra_e;
  logic [3:0] wa_e, wa_m, wa_w;
  logic       regwrite_e, regwrite_m, regwrite_w;
  logic       memtoreg_e, memop_m, mem_ready;
  logic       pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w;
  logic       branch_taken_e;

  logic [3:0]  fwd_a, fwd_b;
  logic        sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a, mw_a, me_a;
  logic        sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b, mw_b, me_b;
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .FWD_EN(1), .TIMEOUT(4), .CW(16)
  ) dut_a (
    .clk(clk), .reset(reset),
    .ra_d(ra_d), .ra_e(ra_e),
    .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memop_m(memop_m),
    .mem_ready(mem_ready),
    .pcsrc_d(pcsrc_d), .pcsrc_e(pcsrc_e),
    .pcsrc_m(pcsrc_m), .pcsrc_w(pcsrc_w),
    .branch_taken_e(branch_taken_e),
    .fwd_e(fwd_a),
    .stall_f(sf_a), .stall_d(sd_a), .stall_e(se_a), .stall_m(sm_a),
    .flush_d(fd_a), .flush_e(fe_a), .flush_w(fw_a),
    .mem_wait(mw_a), .mem_err(me_a),
    .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  pipeline_hazard_ctrl #(
    .FWD_EN(0), .TIMEOUT(255), .CW(4)
  ) dut_b (
    .clk(clk), .reset(reset),
    .ra_d(ra_d), .ra_e(ra_e),
    .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memop_m(memop_m),
    .mem_ready(mem_ready),
    .pcsrc_d(pcsrc_d), .pcsrc_e(pcsrc_e),
    .pcsrc_m(pcsrc_m), .pcsrc_w(pcsrc_w),
    .branch_taken_e(branch_taken_e),
    .fwd_e(fwd_b),
    .stall_f(sf_b), .stall_d(sd_b), .stall_e(se_b), .stall_m(sm_b),
    .flush_d(fd_b), .flush_e(fe_b), .flush_w(fw_b),
    .mem_wait(mw_b), .mem_err(me_b),
    .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ra_d = '0; ra_e = '0;
    wa_e = '0; wa_m = '0; wa_w = '0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    memtoreg_e = 0; memop_m = 0; mem_ready = 0;
    pcsrc_d = 0; pcsrc_e = 0; pcsrc_m = 0; pcsrc_w = 0;
    branch_taken_e = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
    chk("rst_mem_wait", mw_a, 0);
    chk("rst_mem_err", me_a, 0);
    chk("rst_stall_cnt", sc_a, 0);
    chk("rst_flush_cnt", fc_a, 0);
    chk("rst_stall_f", sf_a, 0);

    // forwarding priority
    ra_e = 8'h33; wa_m = 3; regwrite_m = 1; wa_w = 3; regwrite_w = 1;
    #1;
    chk("fwd_m_pri", fwd_a, 4'b1010);
    chk("fwd_off_b", fwd_b, 4'b0000);
    regwrite_m = 0;
    #1;
    chk("fwd_w", fwd_a, 4'b0101);
    ra_e = 8'h73; wa_m = 7; regwrite_m = 1;
    #1;
    chk("fwd_mixed", fwd_a, 4'b1001);
    step();
    idle();

    // load-use
    memtoreg_e = 1; wa_e = 5; ra_d = 8'h50;
    #1;
    chk("lu_stall_f", sf_a, 1);
    chk("lu_stall_d", sd_a, 1);
    chk("lu_flush_e", fe_a, 1);
    chk("lu_flush_d", fd_a, 0);
    chk("lu_stall_e", se_a, 0);
    step();
    chk("lu_stall_cnt", sc_a, 1);

    // load-use plus taken branch
    branch_taken_e = 1;
    #1;
    chk("lub_flush_e", fe_a, 1);
    chk("lub_stall_d", sd_a, 1);
    chk("lub_flush_d", fd_a, 1);
    step();
    branch_taken_e = 0;

    // pcsrc_w plus load-use
    pcsrc_w = 1;
    #1;
    chk("pcw_flush_d", fd_a, 1);
    chk("pcw_stall_d", sd_a, 1);
    step();
    idle();
    chk("cnt_stall3", sc_a, 3);
    chk("cnt_flush2", fc_a, 2);

    reset = 1;
    step();
    reset = 0;
    chk("rst2_stall_cnt", sc_a, 0);
    chk("rst2_flush_cnt", fc_a, 0);

    // PC write walking down the pipe
    pcsrc_d = 1;
    #1;
    chk("pc1_stall_f", sf_a, 1);
    chk("pc1_flush_d", fd_a, 1);
    chk("pc1_stall_d", sd_a, 0);
    step();
    pcsrc_d = 0; pcsrc_e = 1;
    #1;
    chk("pc2_stall_f", sf_a, 1);
    step();
    pcsrc_e = 0; pcsrc_m = 1;
    #1;
    chk("pc3_stall_f", sf_a, 1);
    step();
    pcsrc_m = 0; pcsrc_w = 1;
    #1;
    chk("pc4_stall_f", sf_a, 0);
    chk("pc4_flush_d", fd_a, 1);
    step();
    idle();
    chk("pc_flush_cnt", fc_a, 4);
    chk("pc_stall_cnt", sc_a, 3);

    // memory wait, branch held across it
    memop_m = 1; mem_ready = 0; branch_taken_e = 1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("mw%0d_stall_f", c), sf_a, 1);
      chk($sformatf("mw%0d_stall_e", c), se_a, 1);
      chk($sformatf("mw%0d_stall_m", c), sm_a, 1);
      chk($sformatf("mw%0d_flush_w", c), fw_a, 1);
      chk($sformatf("mw%0d_flush_e", c), fe_a, 0);
      chk($sformatf("mw%0d_flush_d", c), fd_a, 0);
      chk($sformatf("mw%0d_mem_wait", c), mw_a, (c == 1) ? 0 : 1);
      step();
    end
    mem_ready = 1;
    #1;
    chk("mw4_stall_e", se_a, 0);
    chk("mw4_flush_e", fe_a, 1);
    chk("mw4_flush_w", fw_a, 0);
    chk("mw4_mem_wait", mw_a, 1);
    step();
    idle();
    chk("mw5_mem_wait", mw_a, 0);
    chk("mw5_mem_err", me_a, 0);
    chk("mw_stall_cnt", sc_a, 6);
    chk("mw_flush_cnt", fc_a, 5);

    // timeout
    memop_m = 1; mem_ready = 0;
    step();
    chk("to_enter", mw_a, 1);
    repeat (4) step();
    chk("to_e5_err", me_a, 0);
    step();
    chk("to_e6_err", me_a, 1);
    mem_ready = 1;
    step();
    chk("to_exit_wait", mw_a, 0);
    chk("to_sticky1", me_a, 1);
    idle();
    step();
    chk("to_sticky2", me_a, 1);
    chk("to_b_no_err", me_b, 0);
    reset = 1;
    step();
    reset = 0;
    chk("to_rst_err", me_a, 0);

    // reset while waiting
    memop_m = 1; mem_ready = 0;
    step();
    chk("rw_wait", mw_a, 1);
    reset = 1;
    #1;
    chk("rw_comb_stall_m", sm_a, 1);
    step();
    chk("rw_run", mw_a, 0);
    chk("rw_cnt", sc_a, 0);
    reset = 0;
    idle();
    step();

    // stall-only mode
    regwrite_m = 1; wa_m = 2; ra_d = 8'h20; ra_e = 8'h22;
    #1;
    chk("so_b_stall_d", sd_b, 1);
    chk("so_b_flush_e", fe_b, 1);
    chk("so_b_fwd", fwd_b, 4'b0000);
    chk("so_a_stall_d", sd_a, 0);
    chk("so_a_fwd", fwd_a, 4'b1010);
    step();
    regwrite_m = 0; regwrite_e = 1; wa_e = 4; ra_d = 8'h04;
    #1;
    chk("so_e_b_stall_d", sd_b, 1);
    chk("so_e_b_flush_e", fe_b, 1);
    chk("so_e_a_stall_d", sd_a, 0);
    step();
    pcsrc_d = 1;
    repeat (20) step();
    idle();
    chk("sat_b_stall_cnt", sc_b, 15);
    chk("sat_b_flush_cnt", fc_b, 15);
    chk("sat_a_stall_cnt", sc_a, 20);
    chk("sat_a_flush_cnt", fc_a, 20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
